// File: rtl/pcie_ext_cap_list_walker.sv
// Walks the PCIe extended capability list from START_OFFSET until target_cap_id, end of list or fault.
// Optional read-ack timeout is enabled with `define PCIE_ECAP_RD_TIMEOUT_EN.
module pcie_ext_cap_list_walker #(
  parameter logic [11:0] START_OFFSET = 12'h100,
  parameter int unsigned MAX_HOPS     = 64,
  parameter int unsigned RD_TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] target_cap_id,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] found_offset,
  output logic [3:0]  found_version,
  output logic [2:0]  err_code,
  output logic        cfg_rd_req,
  output logic [11:0] cfg_rd_addr,
  input  logic        cfg_rd_ack,
  input  logic [31:0] cfg_rd_data,
  output logic        hdr_valid,
  output logic [31:0] hdr_data
);

  localparam int unsigned   HopW        = $clog2(MAX_HOPS + 1);
  localparam logic [HopW-1:0] HopLast   = HopW'(MAX_HOPS - 1);
  localparam logic [2:0]    ErrNone     = 3'd0;
  localparam logic [2:0]    ErrBadPtr   = 3'd1;
  localparam logic [2:0]    ErrHopLimit = 3'd2;
  localparam logic [2:0]    ErrAllOnes  = 3'd3;

  if (MAX_HOPS < 1 || RD_TIMEOUT < 1) begin : g_param_check
    $error("MAX_HOPS and RD_TIMEOUT must both be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StReq, StCheck} state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic [11:0]       found_offset_q, found_offset_d;
  logic [3:0]        found_version_q, found_version_d;
  logic [2:0]        err_q, err_d;
  logic [11:0]       addr_q, addr_d;
  logic [HopW-1:0]   hop_q, hop_d;
  logic [15:0]       target_q, target_d;
  logic [31:0]       hdr_data_q, hdr_data_d;
  logic              hdr_valid_q, hdr_valid_d;
  logic              walk_end;
  logic [11:0]       next_ptr;

`ifdef PCIE_ECAP_RD_TIMEOUT_EN
  localparam int unsigned     TmoW       = $clog2(RD_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast    = TmoW'(RD_TIMEOUT - 1);
  localparam logic [2:0]      ErrTimeout = 3'd4;
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  assign next_ptr = hdr_data_q[31:20];

  always_comb begin
    state_d         = state_q;
    done_d          = 1'b0;
    found_d         = found_q;
    found_offset_d  = found_offset_q;
    found_version_d = found_version_q;
    err_d           = err_q;
    addr_d          = addr_q;
    hop_d           = hop_q;
    target_d        = target_q;
    hdr_data_d      = hdr_data_q;
    hdr_valid_d     = 1'b0;
    walk_end        = 1'b0;
`ifdef PCIE_ECAP_RD_TIMEOUT_EN
    // Only counts while waiting; any other state leaves it at zero for the next REQ entry.
    tmo_d = (state_q == StReq) ? tmo_q + TmoW'(1) : '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d        = target_cap_id;
          addr_d          = START_OFFSET;
          hop_d           = '0;
          found_d         = 1'b0;
          found_offset_d  = '0;
          found_version_d = '0;
          err_d           = ErrNone;
          state_d         = StReq;
        end
      end
      StReq: begin
        if (cfg_rd_ack) begin
          hdr_data_d  = cfg_rd_data;
          hdr_valid_d = 1'b1;
          state_d     = StCheck;
        end
`ifdef PCIE_ECAP_RD_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          err_d    = ErrTimeout;
          walk_end = 1'b1;
        end
`endif
      end
      StCheck: begin
        if (hdr_data_q == 32'hFFFF_FFFF) begin
          err_d    = ErrAllOnes;
          walk_end = 1'b1;
        end else if (hop_q == '0 && hdr_data_q == 32'h0) begin
          walk_end = 1'b1;
        end else if (hdr_data_q[15:0] == target_q) begin
          found_d         = 1'b1;
          found_offset_d  = addr_q;
          found_version_d = hdr_data_q[19:16];
          walk_end        = 1'b1;
        end else if (next_ptr == 12'h000) begin
          walk_end = 1'b1;
        end else if (next_ptr < 12'h100 || next_ptr[1:0] != 2'b00) begin
          err_d    = ErrBadPtr;
          walk_end = 1'b1;
        end else if (hop_q == HopLast) begin
          err_d    = ErrHopLimit;
          walk_end = 1'b1;
        end else begin
          addr_d  = next_ptr;
          hop_d   = hop_q + HopW'(1);
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    if (walk_end) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      done_q          <= 1'b0;
      found_q         <= 1'b0;
      found_offset_q  <= '0;
      found_version_q <= '0;
      err_q           <= ErrNone;
      addr_q          <= '0;
      hop_q           <= '0;
      target_q        <= '0;
      hdr_data_q      <= '0;
      hdr_valid_q     <= 1'b0;
`ifdef PCIE_ECAP_RD_TIMEOUT_EN
      tmo_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      done_q          <= done_d;
      found_q         <= found_d;
      found_offset_q  <= found_offset_d;
      found_version_q <= found_version_d;
      err_q           <= err_d;
      addr_q          <= addr_d;
      hop_q           <= hop_d;
      target_q        <= target_d;
      hdr_data_q      <= hdr_data_d;
      hdr_valid_q     <= hdr_valid_d;
`ifdef PCIE_ECAP_RD_TIMEOUT_EN
      tmo_q           <= tmo_d;
`endif
    end
  end

  assign busy          = (state_q != StIdle);
  assign cfg_rd_req    = (state_q == StReq);
  assign cfg_rd_addr   = addr_q;
  assign done          = done_q;
  assign found         = found_q;
  assign found_offset  = found_offset_q;
  assign found_version = found_version_q;
  assign err_code      = err_q;
  assign hdr_valid     = hdr_valid_q;
  assign hdr_data      = hdr_data_q;

endmodule

// File: tb/tb_pcie_ext_cap_list_walker.sv
// Directed bench for pcie_ext_cap_list_walker; config space is a word array answering acks
// in the same cycle as the request.
module tb_pcie_ext_cap_list_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] target_cap_id = 16'h0;
  logic        busy, done, found, cfg_rd_req, cfg_rd_ack, hdr_valid;
  logic [11:0] found_offset, cfg_rd_addr;
  logic [3:0]  found_version;
  logic [2:0]  err_code;
  logic [31:0] cfg_rd_data, hdr_data;

  logic        resp_en = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] mem [0:1023];

  assign cfg_rd_ack  = (resp_en & cfg_rd_req) | stray_ack;
  assign cfg_rd_data = mem[cfg_rd_addr[11:2]];

  pcie_ext_cap_list_walker #(
    .START_OFFSET (12'h100),
    .MAX_HOPS     (4),
    .RD_TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .target_cap_id (target_cap_id),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .found_offset  (found_offset),
    .found_version (found_version),
    .err_code      (err_code),
    .cfg_rd_req    (cfg_rd_req),
    .cfg_rd_addr   (cfg_rd_addr),
    .cfg_rd_ack    (cfg_rd_ack),
    .cfg_rd_data   (cfg_rd_data),
    .hdr_valid     (hdr_valid),
    .hdr_data      (hdr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rd_count = 0;
  int          hv_count = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every hdr_valid must carry the word returned by the immediately preceding read.
  always @(negedge clk) begin
    if (hdr_valid) begin
      hv_count++;
      check("hdr_data", hdr_data, last_rd);
    end
    if (cfg_rd_req && cfg_rd_ack) begin
      rd_count++;
      last_rd = cfg_rd_data;
    end
  end

  // Holds start for two cycles so the second (busy) cycle exercises the ignore path.
  task automatic run_walk(input logic [15:0] tgt, input int budget,
                          output int reads, output int lat);
    int rd0;
    int n0;
    bit seen;
    rd0 = rd_count;
    target_cap_id = tgt;
    start = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    check("busy_on_start", 32'(busy), 32'd1);
    check("found_clr", 32'(found), 32'd0);
    check("err_clr", 32'(err_code), 32'd0);
    check("offset_clr", 32'(found_offset), 32'd0);
    target_cap_id = 16'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    lat   = cyc - n0;
    reads = rd_count - rd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int reads, lat;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_offset", 32'(found_offset), 32'd0);
    check("rst_version", 32'(found_version), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_req", 32'(cfg_rd_req), 32'd0);
    check("rst_addr", 32'(cfg_rd_addr), 32'd0);
    check("rst_hv", 32'(hdr_valid), 32'd0);
    check("rst_hdr", hdr_data, 32'd0);

    // Ack without a request must be ignored.
    mem[10'h040] = 32'h1234_5678;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_hv", 32'(hdr_valid), 32'd0);
    @(negedge clk);
    check("stray_hdr", hdr_data, 32'd0);

    // Two-entry list, match on the second header.
    resp_en = 1'b1;
    mem[10'h040] = 32'h1480_0001;
    mem[10'h052] = 32'h0001_000B;
    run_walk(16'h000B, 40, reads, lat);
    check("t1_reads", reads, 32'd2);
    check("t1_lat", lat, 32'd4);
    check("t1_found", 32'(found), 32'd1);
    check("t1_offset", 32'(found_offset), 32'h148);
    check("t1_version", 32'(found_version), 32'd1);
    check("t1_err", 32'(err_code), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_found_hold", 32'(found), 32'd1);

    // Empty list.
    mem[10'h040] = 32'h0;
    run_walk(16'h000B, 40, reads, lat);
    check("t2_reads", reads, 32'd1);
    check("t2_lat", lat, 32'd2);
    check("t2_found", 32'(found), 32'd0);
    check("t2_err", 32'(err_code), 32'd0);

    // Match on the first header, which is also the last.
    mem[10'h040] = 32'h0002_000B;
    run_walk(16'h000B, 40, reads, lat);
    check("t3_reads", reads, 32'd1);
    check("t3_found", 32'(found), 32'd1);
    check("t3_offset", 32'(found_offset), 32'h100);
    check("t3_version", 32'(found_version), 32'd2);

    // Self-loop, started in the done cycle of the previous walk.
    mem[10'h040] = 32'h1000_0001;
    run_walk(16'h0005, 60, reads, lat);
    check("t4_reads", reads, 32'd4);
    check("t4_lat", lat, 32'd8);
    check("t4_err", 32'(err_code), 32'd2);
    check("t4_found", 32'(found), 32'd0);

    mem[10'h040] = 32'h0FC0_0001;
    run_walk(16'h0005, 40, reads, lat);
    check("t5a_reads", reads, 32'd1);
    check("t5a_err", 32'(err_code), 32'd1);

    mem[10'h040] = 32'h1020_0001;
    run_walk(16'h0005, 40, reads, lat);
    check("t5b_reads", reads, 32'd1);
    check("t5b_err", 32'(err_code), 32'd1);

    // All-ones outranks an ID match.
    mem[10'h040] = 32'hFFFF_FFFF;
    run_walk(16'hFFFF, 40, reads, lat);
    check("t5c_err", 32'(err_code), 32'd3);
    check("t5c_found", 32'(found), 32'd0);

    // List ends at the second header without a match.
    mem[10'h040] = 32'h1480_0001;
    mem[10'h052] = 32'h0000_0002;
    run_walk(16'h0005, 40, reads, lat);
    check("t5d_reads", reads, 32'd2);
    check("t5d_err", 32'(err_code), 32'd0);
    check("t5d_found", 32'(found), 32'd0);

    // Config space stops answering.
    resp_en = 1'b0;
`ifdef PCIE_ECAP_RD_TIMEOUT_EN
    run_walk(16'h0001, 40, reads, lat);
    check("t6_err", 32'(err_code), 32'd4);
    check("t6_lat", lat, 32'd8);
    check("t6_reads", reads, 32'd0);
    check("t6_req", 32'(cfg_rd_req), 32'd0);
    check("t6_found", 32'(found), 32'd0);
    target_cap_id = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
`else
    target_cap_id = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) @(negedge clk);
    check("t6_busy_hold", 32'(busy), 32'd1);
    check("t6_done", 32'(done), 32'd0);
`endif

    // Reset while a request is outstanding.
    @(negedge clk);
    check("t7_req_before", 32'(cfg_rd_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_req", 32'(cfg_rd_req), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_err", 32'(err_code), 32'd0);
    check("t7_addr", 32'(cfg_rd_addr), 32'd0);
    check("t7_hdr", hdr_data, 32'd0);
    rst = 1'b0;
    resp_en = 1'b1;
    mem[10'h052] = 32'h0001_000B;
    @(negedge clk);
    run_walk(16'h000B, 40, reads, lat);
    check("t7_reads", reads, 32'd2);
    check("t7_found", 32'(found), 32'd1);
    check("t7_offset", 32'(found_offset), 32'h148);

    @(negedge clk);
    check("hv_vs_reads", hv_count, rd_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
